// File: rtl/acc_cpu_pkg.sv
// Shared opcode and state encodings for the acc_cpu accumulator processor.
package acc_cpu_pkg;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_INPUT = 3'd4;
    localparam logic [2:0] OP_JZ    = 3'd5;
    localparam logic [2:0] OP_JPOS  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    // Execute states sit at 8 + opcode, so decode is a concatenation.
    function automatic state_t exec_state(input logic [2:0] op);
        return state_t'({1'b1, op});
    endfunction

endpackage

// File: rtl/acc_cpu_mem.sv
// Program/data memory: asynchronous read, single synchronous write port, no reset.
module acc_cpu_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/acc_cpu.sv
// Parametrised accumulator CPU with program-load port.
// Define ACC_CPU_DBG_EN to expose IRop_out and StateNoout.
//
// state  | meaning
// START  | one idle cycle after reset
// FETCH  | IR <- M[PC], PC <- PC+1
// DECODE | branch to 8 + opcode
// LOAD   | A <- M[addr]
// STORE  | M[addr] <- A
// ADD    | A <- A + M[addr]
// SUB    | A <- A - M[addr]
// INPUT  | wait for rising edge of enter, then A <- Nin
// JZ     | PC <- addr when A == 0
// JPOS   | PC <- addr when A > 0 (signed)
// HALT   | absorbing until reset; program load allowed
module acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enter,
    input  logic [DATA_W-1:0] Nin,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              halt,
    output logic [DATA_W-1:0] Nout
`ifdef ACC_CPU_DBG_EN
    ,
    output logic [2:0]        IRop_out,
    output logic [3:0]        StateNoout
`endif
);

    if (DATA_W < ADDR_W + 3) begin : g_bad_width
        $error("acc_cpu: DATA_W must be at least ADDR_W+3");
    end

    state_t            state, state_nx;
    logic [DATA_W-1:0] a, a_nx;
    logic [DATA_W-1:0] ir, ir_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic              enter_q;

    logic [2:0]        op;
    logic [ADDR_W-1:0] ir_addr;
    logic              unused_ir;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign op        = ir[DATA_W-1 -: 3];
    assign ir_addr   = ir[ADDR_W-1:0];
    assign unused_ir = ^ir;

    assign rd_addr = (state == S_FETCH) ? pc : ir_addr;

    // Program load only in reset/HALT, so it never competes with STORE.
    always_comb begin
        if (reset || state == S_HALT) begin
            mem_we = prog_we;
            mem_wa = prog_addr;
            mem_wd = prog_data;
        end else begin
            mem_we = (state == S_STORE);
            mem_wa = ir_addr;
            mem_wd = a;
        end
    end

    acc_cpu_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .we      (mem_we),
        .wr_addr (mem_wa),
        .wr_data (mem_wd),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_START;
            a       <= '0;
            ir      <= '0;
            pc      <= '0;
            enter_q <= 1'b0;
        end else begin
            state   <= state_nx;
            a       <= a_nx;
            ir      <= ir_nx;
            pc      <= pc_nx;
            enter_q <= enter;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a;
        ir_nx    = ir;
        pc_nx    = pc;
        case (state)
            S_START:  state_nx = S_FETCH;
            S_FETCH: begin
                ir_nx    = rd_data;
                pc_nx    = pc + ADDR_W'(1);
                state_nx = S_DECODE;
            end
            S_DECODE: state_nx = exec_state(op);
            S_LOAD: begin
                a_nx     = rd_data;
                state_nx = S_FETCH;
            end
            S_STORE:  state_nx = S_FETCH;
            S_ADD: begin
                a_nx     = a + rd_data;
                state_nx = S_FETCH;
            end
            S_SUB: begin
                a_nx     = a - rd_data;
                state_nx = S_FETCH;
            end
            S_INPUT: begin
                if (enter && !enter_q) begin
                    a_nx     = Nin;
                    state_nx = S_FETCH;
                end
            end
            S_JZ: begin
                if (a == '0) begin
                    pc_nx = ir_addr;
                end
                state_nx = S_FETCH;
            end
            S_JPOS: begin
                if (!a[DATA_W-1] && a != '0) begin
                    pc_nx = ir_addr;
                end
                state_nx = S_FETCH;
            end
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_START;
        endcase
    end

    assign halt = (state == S_HALT);
    assign Nout = a;

`ifdef ACC_CPU_DBG_EN
    assign IRop_out   = op;
    assign StateNoout = state;
`endif

endmodule

// File: tb/tb_acc_cpu.sv
// Self-checking bench for acc_cpu: instruction-level model plus directed and random programs.
module tb_acc_cpu;
    import acc_cpu_pkg::*;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enter = 1'b0;
    logic          prog_we = 1'b0;
    logic [DW-1:0] Nin = '0;
    logic [DW-1:0] prog_data = '0;
    logic [AW-1:0] prog_addr = '0;
    logic          halt;
    logic [DW-1:0] Nout;
`ifdef ACC_CPU_DBG_EN
    logic [2:0]    IRop_out;
    logic [3:0]    StateNoout;
`endif

    acc_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .enter     (enter),
        .Nin       (Nin),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .halt      (halt),
        .Nout      (Nout)
`ifdef ACC_CPU_DBG_EN
        ,
        .IRop_out  (IRop_out),
        .StateNoout(StateNoout)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: step = where we are in the current instruction
    // (-1 idle after reset, 0 fetch, 1 decode, 2 execute).
    logic [DW-1:0] mm [32];
    logic [DW-1:0] ma, mir;
    logic [AW-1:0] mpc;
    logic          mhalt, meq;
    int            mstep;
    logic [2:0]    mop;
    logic [AW-1:0] madr;
    assign mop  = mir[DW-1 -: 3];
    assign madr = mir[AW-1:0];

    always @(posedge clock) begin
        if (reset) begin
            if (prog_we) mm[prog_addr] <= prog_data;
            ma <= '0; mir <= '0; mpc <= '0; mhalt <= 1'b0; meq <= 1'b0; mstep <= -1;
        end else begin
            meq <= enter;
            if (mhalt) begin
                if (prog_we) mm[prog_addr] <= prog_data;
            end else if (mstep == -1) begin
                mstep <= 0;
            end else if (mstep == 0) begin
                mir <= mm[mpc]; mpc <= mpc + 1'b1; mstep <= 1;
            end else if (mstep == 1) begin
                if (mop == OP_HALT) mhalt <= 1'b1;
                else mstep <= 2;
            end else begin
                mstep <= 0;
                case (mop)
                    OP_LOAD:  ma <= mm[madr];
                    OP_STORE: mm[madr] <= ma;
                    OP_ADD:   ma <= ma + mm[madr];
                    OP_SUB:   ma <= ma - mm[madr];
                    OP_INPUT: if (enter && !meq) ma <= Nin; else mstep <= 2;
                    OP_JZ:    if (ma == 0) mpc <= madr;
                    OP_JPOS:  if (!ma[DW-1] && ma != 0) mpc <= madr;
                    default:  ;
                endcase
            end
        end
    end

`ifdef ACC_CPU_DBG_EN
    function automatic logic [3:0] exp_state();
        if (mhalt) return 4'd15;
        if (mstep == -1) return 4'd0;
        if (mstep == 0) return 4'd1;
        if (mstep == 1) return 4'd2;
        return {1'b1, mop};
    endfunction
`endif

    always @(negedge clock) begin
        if (chk_en) begin
            chk("nout", 32'(Nout), 32'(ma));
            chk("halt", 32'(halt), 32'(mhalt));
`ifdef ACC_CPU_DBG_EN
            chk("state_no", 32'(StateNoout), 32'(exp_state()));
            chk("ir_op", 32'(IRop_out), 32'(mop));
`endif
        end
    end

    // Records every change of Nout while rec_en is high.
    logic [DW-1:0] seen [$];
    logic          rec_en = 1'b0;
    logic [DW-1:0] last_nout;
    always @(negedge clock) begin
        if (!rec_en) last_nout <= Nout;
        else if (Nout !== last_nout) begin
            seen.push_back(Nout);
            last_nout <= Nout;
        end
    end

    task automatic check_seq(input string name, input logic [DW-1:0] expq [$]);
        chk({name, "_len"}, 32'(seen.size()), 32'(expq.size()));
        foreach (expq[i]) begin
            if (i < seen.size()) chk(name, 32'(seen[i]), 32'(expq[i]));
        end
    endtask

    task automatic load_word(input logic [AW-1:0] ad, input logic [DW-1:0] d);
        prog_we = 1'b1; prog_addr = ad; prog_data = d;
        @(negedge clock);
        prog_we = 1'b0;
    endtask

    task automatic load_countdown();
        load_word(5'd0, 8'h80);   // INPUT
        load_word(5'd1, 8'hA4);   // JZ 4
        load_word(5'd2, 8'h7F);   // SUB 31
        load_word(5'd3, 8'hC1);   // JPOS 1
        load_word(5'd4, 8'hE0);   // HALT
        load_word(5'd31, 8'h01);
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (!halt && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_halted"}, 32'(halt), 32'd1);
    endtask

    logic [DW-1:0] expq [$];

    initial begin
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        for (int i = 0; i < 32; i++) load_word(AW'(i), '0);

        // Reset held with enter toggling.
        for (int i = 0; i < 4; i++) begin
            enter = ~enter;
            @(negedge clock);
            chk("rst_halt", 32'(halt), 32'd0);
            chk("rst_nout", 32'(Nout), 32'd0);
            chk("rst_state", 32'(dut.state), 32'(S_START));
        end
        enter = 1'b0;

        // Countdown from 9.
        load_countdown();
        reset = 1'b0;
        chk("rel_state0", 32'(dut.state), 32'(S_START));
        @(negedge clock);
        chk("rel_state1", 32'(dut.state), 32'(S_FETCH));
        repeat (4) @(negedge clock);
        seen.delete();
        rec_en = 1'b1;
        Nin = 8'd9;
        enter = 1'b1;
        @(negedge clock);
        enter = 1'b0;
        run_to_halt("countdown", 400);
        rec_en = 1'b0;
        expq.delete();
        for (int k = 9; k >= 0; k--) expq.push_back(DW'(k));
        check_seq("countdown_seq", expq);
        repeat (5) @(negedge clock);
        chk("halt_sticky", 32'(halt), 32'd1);
        chk("halt_nout", 32'(Nout), 32'd0);

        // Enter held across INPUT entry, then wrap arithmetic.
        reset = 1'b1;
        load_word(5'd0, 8'h80);   // INPUT
        load_word(5'd1, 8'h50);   // ADD 16
        load_word(5'd2, 8'hC6);   // JPOS 6
        load_word(5'd3, 8'h11);   // LOAD 17
        load_word(5'd4, 8'h72);   // SUB 18
        load_word(5'd5, 8'hE0);
        load_word(5'd6, 8'hE0);
        load_word(5'd16, 8'h02);
        load_word(5'd17, 8'h00);
        load_word(5'd18, 8'h01);
        Nin = 8'h7F;
        enter = 1'b1;
        reset = 1'b0;
        repeat (8) @(negedge clock);
        chk("held_enter_nout", 32'(Nout), 32'd0);
        load_word(5'd2, 8'h00);   // must be ignored mid-run
        seen.delete();
        rec_en = 1'b1;
        enter = 1'b0;
        @(negedge clock);
        enter = 1'b1;
        @(negedge clock);
        chk("capture_nout", 32'(Nout), 32'h7F);
        enter = 1'b0;
        run_to_halt("wrap", 100);
        rec_en = 1'b0;
        expq = '{8'h7F, 8'h81, 8'h00, 8'hFF};
        check_seq("wrap_seq", expq);
        chk("wrap_final", 32'(Nout), 32'hFF);
        chk("mem2_locked", 32'(dut.u_mem.mem[2]), 32'hC6);
        load_word(5'd2, 8'h55);
        @(negedge clock);
        chk("mem2_halt_write", 32'(dut.u_mem.mem[2]), 32'h55);

        // PC wrap 31 -> 0.
        reset = 1'b1;
        load_word(5'd0, 8'hBE);   // JZ 30
        load_word(5'd1, 8'hE0);   // HALT
        load_word(5'd29, 8'h03);
        load_word(5'd30, 8'h1D);  // LOAD 29
        load_word(5'd31, 8'h5D);  // ADD 29
        reset = 1'b0;
        run_to_halt("pcwrap", 100);
        chk("pcwrap_nout", 32'(Nout), 32'h06);
        chk("pcwrap_pc", 32'(dut.pc), 32'd2);

        // Reset during INPUT wait keeps memory.
        reset = 1'b1;
        load_countdown();
        reset = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_nout", 32'(Nout), 32'd0);
        chk("midreset_pc", 32'(dut.pc), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        seen.delete();
        rec_en = 1'b1;
        Nin = 8'd3;
        enter = 1'b1;
        @(negedge clock);
        enter = 1'b0;
        run_to_halt("rerun", 200);
        rec_en = 1'b0;
        expq = '{8'h03, 8'h02, 8'h01, 8'h00};
        check_seq("rerun_seq", expq);

        // Random programs with random enter/Nin/prog_we activity.
        for (int it = 0; it < 12; it++) begin
            reset = 1'b1;
            for (int i = 0; i < 32; i++) load_word(AW'(i), 8'($urandom));
            reset = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 3) == 0) enter = ~enter;
                if ($urandom_range(0, 7) == 0) Nin = 8'($urandom);
                prog_we = ($urandom_range(0, 7) == 0);
                prog_addr = 5'($urandom);
                prog_data = 8'($urandom);
                @(negedge clock);
            end
            prog_we = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
